dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port word data memory (combinational read, write on posedge CLK).
- Port 0 is the processor load/store path; port 1 is the DMA/debug loader.
- Grants one access at a time with round-robin fairness, drives the memory from registered commands, and returns registered read data with a one-cycle ACK.

Parameters:
- AW, 32, address width of requester and memory ports (byte addresses).
- DW, 32, data width.
- DEPTH_WORDS, 128, memory depth in words; used only by the optional range check.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous reset, active-low.
- REQ0  in  1  port-0 request; held with WE0/A0/WD0 stable until ACK0.
- WE0  in  1  port-0 write enable (1 = write, 0 = read).
- A0  in  AW  port-0 byte address.
- WD0  in  DW  port-0 write data.
- ACK0  out  1  port-0 completion pulse.
- RD0  out  DW  port-0 read data, valid while ACK0 = 1.
- REQ1, WE1, A1, WD1, ACK1, RD1: same as port 0, for port 1.
- MEM_WE  out  1  memory write enable.
- MEM_A  out  AW  memory byte address.
- MEM_WD  out  DW  memory write data.
- MEM_RD  in  DW  memory read data (combinational from MEM_A).
- BUSY  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RST_N.
- Reset values: state = IDLE, OWNER = 0, LAST = 1, ACK0/ACK1 = 0, RD0/RD1 = 0, command registers = 0, BUSY = 0.
- MEM_WE is combinationally gated by RST_N, so no memory write occurs in any cycle where RST_N = 0.
- Reset mid-operation aborts the transaction and produces no ACK.
- FSM states are IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one REQx high: latch {WEx, Ax, WDx} into the command registers, set OWNER = x, go to ACCESS.
  - Both REQ high: grant port (LAST == 0 ? 1 : 0), i.e. the port not served last.
- ACCESS:
  - MEM_A = cmd_A, MEM_WD = cmd_WD, MEM_WE = cmd_WE.
  - On the edge: RD_OWNER <= MEM_RD (reads only; RD is unchanged on writes), LAST <= OWNER, go to RESP.
- RESP:
  - ACK_OWNER = 1 for exactly this cycle.
  - Arbitrate only the other port (REQ_OWNER is treated as the acknowledged request).
  - Other port requesting: latch its command and go to ACCESS (back-to-back).
  - Otherwise: go to IDLE.
- Outside ACCESS: MEM_WE = 0, and MEM_A/MEM_WD hold the command registers.
- Latency: request seen in IDLE -> ACK 2 cycles later. Sustained throughput is one access per 2 cycles.
- A requester must drop REQ or present a new command in the cycle after ACK. A REQ still high then is a new request.
- The memory uses A[31:2] as the word index; the arbiter passes the full byte address unmodified.
- ACK0 and ACK1 are never high in the same cycle.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - Adds outputs ERR0 and ERR1 (1 bit each), both reset to 0.
  - A command with A[AW-1:2] >= DEPTH_WORDS is out of range.
  - Out-of-range write: MEM_WE is forced to 0 in ACCESS.
  - Out-of-range read: RD_OWNER <= 0.
  - ERR_OWNER pulses together with ACK_OWNER.
  - Timing is unchanged.
- Undefined: no ERR ports, no address check; all accesses pass through.

Decomposition:
- Package dmem_arb_pkg:
  - State encoding IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Port id constants PORT_CORE = 1'b0, PORT_DMA = 1'b1.
  - Default widths and depth.
- One sub-module, rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last, mask[1:0]. Outputs: valid, winner.
  - Used in both IDLE and RESP (with mask) arbitration.
- FSM, command registers and response registers stay in dmem_arbiter.

Test Plan:
- Single write then read: REQ0 WE0 = 1, A0 = 0x10, WD0 = 0xDEADBEEF. ACK0 2 cycles after request, with MEM_WE = 1 only in the ACCESS cycle. Then a read of A0 = 0x10 gives ACK0 with RD0 = 0xDEADBEEF.
- Tie after reset: REQ0 and REQ1 rise in the same cycle. Port 0 is acked first; port 1 is acked 2 cycles later (back-to-back via RESP), with no IDLE cycle between.
- Fairness: REQ0 and REQ1 held high continuously with new commands after each ACK. ACKs alternate 0, 1, 0, 1 every 2 cycles; ACK0 and ACK1 are never high together.
- Reset mid-operation: RST_N = 0 during ACCESS of a write with A = 0x20, WD = 0x1. MEM_WE stays 0, memory word 8 is unchanged, no ACK, and BUSY = 0 after the edge.
- Read with no stale data: port 1 reads A = 0x0 (value 0) after port 0 wrote 0x5 to A = 0x4. RD1 = 0; RD0 keeps its last read value.
- DMEM_RANGE_CHECK_EN: write to A = 0x200 (word 128) gives MEM_WE = 0 and ERR0 = 1 with ACK0. A read of 0x200 gives RD0 = 0 and ERR0 = 1. A read of 0x1FC gives ERR0 = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, port ids and default sizes for the data-memory arbiter
package dmem_arb_pkg;
    localparam int AW_DEF    = 32;
    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 128;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; masked requesters are ignored, ties go to the port not served last
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic       valid,
    output logic       winner
);
    logic [1:0] cand;
    assign cand   = req & ~mask;
    assign valid  = |cand;
    assign winner = (cand == 2'b11) ? ~last : cand[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin sequencer in front of a single-port word memory; optional address range check under DMEM_RANGE_CHECK_EN
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter int DEPTH_WORDS = DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ0,
    input  logic          WE0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] WD0,
    output logic          ACK0,
    output logic [DW-1:0] RD0,
    input  logic          REQ1,
    input  logic          WE1,
    input  logic [AW-1:0] A1,
    input  logic [DW-1:0] WD1,
    output logic          ACK1,
    output logic [DW-1:0] RD1,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_A,
    output logic [DW-1:0] MEM_WD,
    input  logic [DW-1:0] MEM_RD,
    output logic          BUSY
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic          ERR0,
    output logic          ERR1
`endif
);
    state_t        state, state_d;
    logic          owner, last, cmd_we, load, oor;
    logic [AW-1:0] cmd_a;
    logic [DW-1:0] cmd_wd, rd_val;
    logic [1:0]    mask;
    logic          pick_valid, pick_winner;

    // in RESP the owner's request is the one just acknowledged, so only the other port competes
    assign mask = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    rr_pick2 u_pick (
        .req   ({REQ1, REQ0}),
        .last  (last),
        .mask  (mask),
        .valid (pick_valid),
        .winner(pick_winner)
    );

`ifdef DMEM_RANGE_CHECK_EN
    assign oor = cmd_a[AW-1:2] >= (AW-2)'(DEPTH_WORDS);
`else
    assign oor = 1'b0;
    logic unused_depth;
    assign unused_depth = DEPTH_WORDS > 0;
`endif

    assign rd_val = oor ? '0 : MEM_RD;
    assign MEM_A  = cmd_a;
    assign MEM_WD = cmd_wd;
    assign MEM_WE = RST_N && (state == ACCESS) && cmd_we && !oor;
    assign BUSY   = state != IDLE;

    // next state: IDLE and RESP both grant when a candidate exists, ACCESS always answers in RESP
    always_comb begin
        load    = ((state == IDLE) || (state == RESP)) && pick_valid;
        state_d = load ? ACCESS : (state == ACCESS) ? RESP : IDLE;
    end

    // state register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_d;
    end

    // command capture on grant, read/ack response registered at the end of ACCESS
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            owner  <= PORT_CORE;
            last   <= PORT_DMA;
            cmd_we <= 1'b0;
            cmd_a  <= '0;
            cmd_wd <= '0;
            ACK0   <= 1'b0;
            ACK1   <= 1'b0;
            RD0    <= '0;
            RD1    <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            ERR0   <= 1'b0;
            ERR1   <= 1'b0;
`endif
        end else begin
            ACK0 <= (state == ACCESS) && (owner == PORT_CORE);
            ACK1 <= (state == ACCESS) && (owner == PORT_DMA);
`ifdef DMEM_RANGE_CHECK_EN
            ERR0 <= (state == ACCESS) && (owner == PORT_CORE) && oor;
            ERR1 <= (state == ACCESS) && (owner == PORT_DMA) && oor;
`endif
            if (load) begin
                owner  <= pick_winner;
                cmd_we <= pick_winner ? WE1 : WE0;
                cmd_a  <= pick_winner ? A1 : A0;
                cmd_wd <= pick_winner ? WD1 : WD0;
            end
            if (state == ACCESS) begin
                last <= owner;
                if (!cmd_we && (owner == PORT_CORE)) RD0 <= rd_val;
                if (!cmd_we && (owner == PORT_DMA))  RD1 <= rd_val;
            end
        end
    end
endmodule
